munoc_monitor_collector: RTL

//  Downstream consumer of the per-port AHB monitors: gathers NUM_MON bandwidth

---
 rtl/munoc_monitor_collector_pkg.sv | 25 ++
 rtl/munoc_monitor_channel.sv | 45 ++++
 rtl/munoc_monitor_collector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/munoc_monitor_collector_pkg.sv
// Shared definitions for the monitor collector: APB word indices (byte
// offset / 4), field positions inside the timeout/mask registers and the
// window-sequencer state encoding.
package munoc_monitor_collector_pkg;

  // Word indices of the register map (byte address >> 2)
  localparam int WI_CTRL   = 0;   // 0x00
  localparam int WI_STATUS = 1;   // 0x04
  localparam int WI_TO     = 2;   // 0x08
  localparam int WI_MASK   = 3;   // 0x0C
  localparam int WI_WCNT   = 4;   // 0x10
  localparam int WI_LAST   = 16;  // 0x40 + 4i
  localparam int WI_PEAK   = 32;  // 0x80 + 4i

  // Field positions
  localparam int RESP_LSB       = 16;  // resp-side timeout bits start here
  localparam int MASK_WDONE_BIT = 31;  // IRQ_MASK bit gating WDONE

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } fsm_t;

endpackage

// File: rtl/munoc_monitor_channel.sv
// One bandwidth channel: remembers the count at the start of the window,
// produces the wrap-safe delta at window end and keeps the peak delta.
// Ports:
//   clk, rstnn  clock / async active-low reset
//   count       free-running wrapping busy count from the monitor
//   prime       capture count as the window start (no LAST/PEAK update)
//   win_end     window boundary: update LAST/PEAK, restart from count
//   peak_clr    APB write to this channel's PEAK register
//   last, peak  LAST and PEAK register contents
module munoc_monitor_channel
  import munoc_monitor_collector_pkg::*;
#(
  parameter int BW_COUNT = 16
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic [BW_COUNT-1:0] count,
  input  logic                prime,
  input  logic                win_end,
  input  logic                peak_clr,
  output logic [BW_COUNT-1:0] last,
  output logic [BW_COUNT-1:0] peak
);

  logic [BW_COUNT-1:0] prev_q;
  logic [BW_COUNT-1:0] delta;

  // Modular subtraction handles a counter wrap inside the window.
  assign delta = count - prev_q;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      prev_q <= '0;
      last   <= '0;
      peak   <= '0;
    end else begin
      if (prime || win_end) prev_q <= count;
      if (win_end)          last   <= delta;
      // A software clear in the same cycle as a window end wins.
      if (peak_clr)                     peak <= '0;
      else if (win_end && delta > peak) peak <= delta;
    end
  end

endmodule

// File: rtl/munoc_monitor_collector.sv
// Collects NUM_MON monitor bandwidth counts and timeout levels into one APB
// register block: per-window deltas (LAST), peaks (PEAK), sticky timeouts
// and a single registered interrupt.
// Ports:
//   clk, rstnn                 clock / async active-low reset
//   enable                     window advances only while 1
//   mon_bw_count               NUM_MON packed wrapping busy counts
//   mon_timeout_req/resp       per-channel timeout levels
//   rpsel..rpwdata             APB slave inputs
//   rprdata, rpready, rpslverr APB slave outputs (zero wait)
//   irq                        masked sticky timeouts | masked WDONE
module munoc_monitor_collector
  import munoc_monitor_collector_pkg::*;
#(
  parameter int NUM_MON  = 4,
  parameter int BW_COUNT = 16,
  parameter int WINDOW   = 1024,
  parameter int BW_ADDR  = 8
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic                        enable,
  input  logic [NUM_MON*BW_COUNT-1:0] mon_bw_count,
  input  logic [NUM_MON-1:0]          mon_timeout_req,
  input  logic [NUM_MON-1:0]          mon_timeout_resp,
  input  logic                        rpsel,
  input  logic                        rpenable,
  input  logic                        rpwrite,
  input  logic [BW_ADDR-1:0]          rpaddr,
  input  logic [31:0]                 rpwdata,
  output logic [31:0]                 rprdata,
  output logic                        rpready,
  output logic                        rpslverr,
  output logic                        irq
);

  localparam int AW  = BW_ADDR - 2;
  localparam int WCW = $clog2(WINDOW);

  // ---------------- APB decode ----------------
  logic          access, wr;
  logic [AW-1:0] widx;
  logic          wr_ctrl, wr_status, wr_to, wr_mask;

  assign access    = rpsel & rpenable;
  assign wr        = access & rpwrite;
  assign widx      = rpaddr[BW_ADDR-1:2];
  assign wr_ctrl   = wr && (widx == AW'(WI_CTRL));
  assign wr_status = wr && (widx == AW'(WI_STATUS));
  assign wr_to     = wr && (widx == AW'(WI_TO));
  assign wr_mask   = wr && (widx == AW'(WI_MASK));
  assign rpready   = 1'b1;

  // Byte-lane bits and unused data bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{rpwdata, rpaddr[1:0]};

  // ---------------- control / status registers ----------------
  logic               run_q, wdone_q, irq_q;
  logic [NUM_MON-1:0] to_req_q, to_resp_q, mask_req_q, mask_resp_q;
  logic               mask_wdone_q;
  logic [NUM_MON-1:0] clr_req, clr_resp;
  logic               prime, win_end;

  assign clr_req  = wr_to ? rpwdata[NUM_MON-1:0]          : '0;
  assign clr_resp = wr_to ? rpwdata[RESP_LSB +: NUM_MON] : '0;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      run_q        <= 1'b0;
      wdone_q      <= 1'b0;
      to_req_q     <= '0;
      to_resp_q    <= '0;
      mask_req_q   <= '0;
      mask_resp_q  <= '0;
      mask_wdone_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_ctrl) run_q <= rpwdata[0];
      // Window end beats a coincident W1C.
      if (win_end)                      wdone_q <= 1'b1;
      else if (wr_status && rpwdata[0]) wdone_q <= 1'b0;
      // New timeout level beats a coincident W1C.
      to_req_q  <= (to_req_q  & ~clr_req)  | mon_timeout_req;
      to_resp_q <= (to_resp_q & ~clr_resp) | mon_timeout_resp;
      if (wr_mask) begin
        mask_req_q   <= rpwdata[NUM_MON-1:0];
        mask_resp_q  <= rpwdata[RESP_LSB +: NUM_MON];
        mask_wdone_q <= rpwdata[MASK_WDONE_BIT];
      end
      irq_q <= |(to_req_q & mask_req_q) | |(to_resp_q & mask_resp_q)
             | (wdone_q & mask_wdone_q);
    end
  end

  assign irq = irq_q;

  // ---------------- window sequencer ----------------
  fsm_t           state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    prime   = 1'b0;
    win_end = 1'b0;
    if (!run_q) begin
      // Stopping is honoured even while enable is low.
      state_d = ST_IDLE;
      wcnt_d  = '0;
    end else if (enable) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: begin
          prime   = 1'b1;
          wcnt_d  = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (wcnt_q == WCW'(WINDOW - 1)) begin
            win_end = 1'b1;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- channels ----------------
  logic [NUM_MON-1:0][BW_COUNT-1:0] last, peak;
  logic [NUM_MON-1:0]               peak_clr;

  for (genvar g = 0; g < NUM_MON; g++) begin : g_ch
    assign peak_clr[g] = wr && (widx == AW'(WI_PEAK + g));
    munoc_monitor_channel #(.BW_COUNT(BW_COUNT)) u_ch (
      .clk      (clk),
      .rstnn    (rstnn),
      .count    (mon_bw_count[g*BW_COUNT +: BW_COUNT]),
      .prime    (prime),
      .win_end  (win_end),
      .peak_clr (peak_clr[g]),
      .last     (last[g]),
      .peak     (peak[g])
    );
  end

  // ---------------- read mux ----------------
  logic [31:0] rdata;
  logic        hit;

  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    case (widx)
      AW'(WI_CTRL):   begin hit = 1'b1; rdata[0] = run_q;   end
      AW'(WI_STATUS): begin hit = 1'b1; rdata[0] = wdone_q; end
      AW'(WI_TO): begin
        hit = 1'b1;
        rdata[NUM_MON-1:0]          = to_req_q;
        rdata[RESP_LSB +: NUM_MON] = to_resp_q;
      end
      AW'(WI_MASK): begin
        hit = 1'b1;
        rdata[NUM_MON-1:0]          = mask_req_q;
        rdata[RESP_LSB +: NUM_MON] = mask_resp_q;
        rdata[MASK_WDONE_BIT]       = mask_wdone_q;
      end
      AW'(WI_WCNT):   begin hit = 1'b1; rdata = 32'(wcnt_q); end
      default: ;
    endcase
    for (int i = 0; i < NUM_MON; i++) begin
      if (widx == AW'(WI_LAST + i)) begin hit = 1'b1; rdata = 32'(last[i]); end
      if (widx == AW'(WI_PEAK + i)) begin hit = 1'b1; rdata = 32'(peak[i]); end
    end
  end

  assign rprdata  = access ? rdata : 32'h0;
  assign rpslverr = access & ~hit;

endmodule
